// File: rtl/demux1_4_deser.sv
// ============================================================================
// Module  : demux1_4_deser
// Brief   : 1-bit serial to 4-bit parallel deserializer with valid/ready on
//           both sides and a single output holding register.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module demux1_4_deser #(
  parameter int MSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_in_valid,
  input  logic       i_in_bit,
  output logic       o_in_ready,
  output logic [3:0] o_out_word,
  output logic       o_out_valid,
  input  logic       i_out_ready
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  state_t     r_cnt;
  logic [2:0] r_part;
  logic [3:0] r_word;
  logic       r_valid;

  logic       w_last;
  logic       w_acc;
  logic [3:0] w_slots;
  logic [3:0] w_mapped;

  // Only the 4th bit needs room in the output register; slots 0-2 always fill.
  assign w_last     = (r_cnt == S3);
  assign o_in_ready = ~i_flush & (~w_last | ~r_valid | i_out_ready);
  assign w_acc      = i_in_valid & o_in_ready;
  assign w_slots    = {i_in_bit, r_part};

  generate
    if (MSB_FIRST != 0) begin : g_msb
      for (genvar k = 0; k < 4; k++) begin : g_bit
        assign w_mapped[3-k] = w_slots[k];
      end
    end else begin : g_lsb
      assign w_mapped = w_slots;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= S0;
      r_part  <= 3'b000;
      r_word  <= 4'b0000;
      r_valid <= 1'b0;
    end else begin
      if (i_flush) begin
        r_cnt <= S0;
      end else if (w_acc) begin
        case (r_cnt)
          S0: begin
            r_part[0] <= i_in_bit;
            r_cnt     <= S1;
          end
          S1: begin
            r_part[1] <= i_in_bit;
            r_cnt     <= S2;
          end
          S2: begin
            r_part[2] <= i_in_bit;
            r_cnt     <= S3;
          end
          default: begin
            r_word <= w_mapped;
            r_cnt  <= S0;
          end
        endcase
      end

      // A completing word wins over a drain so back-to-back words see no bubble.
      if (w_acc && w_last) begin
        r_valid <= 1'b1;
      end else if (r_valid && i_out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_out_word  = r_word;
  assign o_out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_demux1_4_deser.sv
// ============================================================================
// Module  : tb_demux1_4_deser
// Brief   : Directed self-checking bench for demux1_4_deser (both bit orders).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux1_4_deser;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_bit;
  logic       out_ready;
  logic       in_ready_l,  in_ready_m;
  logic [3:0] word_l,      word_m;
  logic       valid_l,     valid_m;

  int n_chk;
  int n_pass;
  logic last_ready;
  int   n_acc;

  demux1_4_deser #(.MSB_FIRST(0)) u_dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_in_valid (in_valid),
    .i_in_bit   (in_bit),
    .o_in_ready (in_ready_l),
    .o_out_word (word_l),
    .o_out_valid(valid_l),
    .i_out_ready(out_ready)
  );

  demux1_4_deser #(.MSB_FIRST(1)) u_dut_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_in_valid (in_valid),
    .i_in_bit   (in_bit),
    .o_in_ready (in_ready_m),
    .o_out_word (word_m),
    .o_out_valid(valid_m),
    .i_out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one cycle of stimulus just after a rising edge, sample in_ready
  // mid-cycle, then return 1 time unit after the next rising edge.
  task automatic beat(input logic v, input logic b, input logic orq, input logic fl);
    in_valid  = v;
    in_bit    = b;
    out_ready = orq;
    flush     = fl;
    @(negedge clk);
    last_ready = in_ready_l;
    if (v && in_ready_l) n_acc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_acc = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid_l, 1'b0);
    chk("rst_word",  word_l,  4'b0000);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", in_ready_l, 1'b1);

    // Reset mid-word: two bits, async reset, then only 4 fresh bits complete.
    beat(1, 0, 1, 0);
    beat(1, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_ready", in_ready_l, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    beat(1, 1, 1, 0);
    beat(1, 1, 1, 0);
    beat(1, 1, 1, 0);
    chk("rst_no_early_word", valid_l, 1'b0);
    beat(1, 1, 1, 0);
    chk("rst_word_valid", valid_l, 1'b1);
    chk("rst_word_1111",  word_l,  4'b1111);

    // Back-to-back words, both bit orders.
    n_acc = 0;
    beat(1, 1, 1, 0);
    chk("drain_on_first_bit", valid_l, 1'b0);
    beat(1, 0, 1, 0);
    beat(1, 1, 1, 0);
    beat(1, 1, 1, 0);
    chk("w1_valid",    valid_l, 1'b1);
    chk("w1_lsb_1101", word_l,  4'b1101);
    chk("w1_msb_1011", word_m,  4'b1011);
    beat(1, 0, 1, 0);
    beat(1, 1, 1, 0);
    beat(1, 0, 1, 0);
    beat(1, 0, 1, 0);
    chk("w2_valid",    valid_l, 1'b1);
    chk("w2_lsb_0010", word_l,  4'b0010);
    chk("w2_msb_0100", word_m,  4'b0100);
    chk("w12_accepts", n_acc,   8);

    // Back-pressure: held word, only 3 more bits accepted while stalled.
    beat(0, 0, 1, 0);
    chk("bp_drained", valid_l, 1'b0);
    beat(1, 0, 0, 0);
    beat(1, 0, 0, 0);
    beat(1, 0, 0, 0);
    beat(1, 1, 0, 0);
    chk("bp_word_1000", word_l, 4'b1000);
    n_acc = 0;
    beat(1, 0, 0, 0);
    beat(1, 1, 0, 0);
    beat(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) beat(1, 0, 0, 0);
    chk("bp_accepts_3",  n_acc,      3);
    chk("bp_ready_low",  last_ready, 1'b0);
    chk("bp_word_held",  word_l,     4'b1000);
    chk("bp_valid_held", valid_l,    1'b1);
    beat(1, 1, 1, 0);
    chk("bp_ready_on_orq", last_ready, 1'b1);
    chk("bp_valid_stays",  valid_l,    1'b1);
    chk("bp_lsb_1110",     word_l,     4'b1110);
    chk("bp_msb_0111",     word_m,     4'b0111);

    // Flush with a pending word (1110) still held.
    beat(1, 1, 0, 0);
    beat(1, 1, 0, 0);
    beat(1, 1, 0, 1);
    chk("fl_ready_low",  last_ready, 1'b0);
    chk("fl_pending_v",  valid_l,    1'b1);
    chk("fl_pending_w",  word_l,     4'b1110);
    beat(1, 0, 1, 0);
    chk("fl_drained", valid_l, 1'b0);
    beat(1, 1, 1, 0);
    beat(1, 0, 1, 0);
    chk("fl_no_early", valid_l, 1'b0);
    beat(1, 1, 1, 0);
    chk("fl_valid",    valid_l, 1'b1);
    chk("fl_lsb_1010", word_l,  4'b1010);

    // Gapped input.
    beat(1, 1, 1, 0);
    beat(0, 0, 1, 0);
    beat(0, 1, 1, 0);
    beat(1, 0, 1, 0);
    beat(0, 1, 1, 0);
    beat(1, 0, 1, 0);
    chk("gap_no_early", valid_l, 1'b0);
    beat(1, 1, 1, 0);
    chk("gap_valid",    valid_l, 1'b1);
    chk("gap_lsb_1001", word_l,  4'b1001);
    chk("gap_msb_1001", word_m,  4'b1001);
    beat(0, 0, 1, 0);
    chk("gap_drain", valid_l, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/demux1_4_deser.md
# demux1_4_deser

Serial-to-parallel deserializer that routes a 1-bit input stream into a 4-bit word. A 2-bit slot counter acts as the select of a 1:4 demultiplexer, so the first accepted bit lands in slot 0 and the fourth in slot 3. This makes it the receive-side counterpart of the 4:1 select path used for parallel-to-serial conversion in the datapath. It sits between a serial source and any 4-bit consumer, with valid/ready handshakes on both sides and a single output holding register.

## Interface
- MSB_FIRST, 0, 0: first accepted bit goes to out_word[0]. 1: first accepted bit goes to out_word[3].
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset. 0 clears all state immediately. Release is sampled on clk.
- flush  in  1  synchronous; discards any partial word and returns the slot counter to 0.
- in_valid  in  1  in_bit is valid this cycle.
- in_bit  in  1  serial data bit.
- in_ready  out  1  block accepts in_bit this cycle. Combinational.
- out_word  out  4  assembled word. Stable while out_valid=1.
- out_valid  out  1  out_word holds an unconsumed word.
- out_ready  in  1  consumer takes out_word this cycle.

## Operation
- State = slot counter cnt (states S0..S3 = number of bits collected), plus a 3-bit partial register part[2:0], plus the output register {out_word, out_valid}.
- Accept: acc = in_valid & in_ready.
- Slot mapping: logical slot k maps to physical bit k when MSB_FIRST=0, and to bit 3-k when MSB_FIRST=1.
- In S0..S2, on acc: part[cnt] <= in_bit; cnt <= cnt+1 (S0→S1→S2→S3).
- In S3, on acc:
  - out_word <= mapped {in_bit, part[2], part[1], part[0]}.
  - out_valid <= 1.
  - cnt wraps to S0.
  - part is not cleared; stale bits are overwritten before reuse.
- Output drain: if out_valid & out_ready and no word completes this cycle, out_valid <= 0. out_word keeps its last value.
- in_ready = ~flush & ((cnt != 3) | ~out_valid | out_ready).
  - Slots 0–2 always fill, even while the output is stalled.
  - Only the 4th bit is blocked by a full output register.
- Word completion and drain in the same cycle: the new word is loaded, out_valid stays 1, and no bubble is inserted.
- flush=1: cnt <= 0; the partial word is discarded; in_ready=0, so in_bit is dropped. The output register and out_valid are unaffected and drain normally.
- in_valid=0: no state change in cnt or part.

## Timing
- Reset values: cnt=S0, part=3'b000, out_word=4'b0000, out_valid=0. in_ready=1 after reset (given flush=0).
- Latency: out_valid rises on the clock edge that accepts the 4th bit, so it is visible the cycle after that bit is presented.
- Throughput: 1 bit/cycle; one word per 4 accepted beats. Sustained indefinitely when out_ready=1.
- Back-pressure: with out_valid=1 and out_ready=0, the block accepts at most 3 further bits, then holds in_ready=0 in S3 until out_ready=1.
- out_word and out_valid are registered outputs with no combinational path from inputs. in_ready is combinational from cnt, out_valid, out_ready and flush.
- Reset asserted mid-word or mid-stall: all state clears asynchronously and the pending word is lost. After release, the first accepted bit maps to slot 0.
- The source must hold in_bit and in_valid until in_ready=1. The consumer samples out_word when out_valid & out_ready.

## Test plan
- Reset check: drive reset=0 mid-stream after 2 accepted bits, then release and send 1,1,1,1 → out_word=4'b1111 after exactly 4 accepts. No residue from the earlier bits.
- Basic LSB-first, MSB_FIRST=0, out_ready=1: stream 1,0,1,1 on consecutive cycles → out_valid=1 one cycle after the 4th bit, out_word=4'b1101. Then stream 0,1,0,0 → out_word=4'b0010 with no idle cycle between words.
- MSB_FIRST=1: stream 1,0,1,1 → out_word=4'b1011.
- Back-pressure: out_ready=0, send 0,0,0,1 → out_word=4'b1000 held. Offer 8 more bits → only 3 accepted, then in_ready=0 in S3. Raise out_ready → in_ready=1 the same cycle; 4th bit accepted; out_valid stays 1 and the next word replaces 4'b1000 on that edge.
- Flush: accept 1,1, assert flush for 1 cycle with in_valid=1 (bit dropped, in_ready=0), then send 0,1,0,1 → out_word=4'b1010. A word pending at flush time is still delivered unchanged.
- Gapped input: in_valid toggling 1,0,0,1,0,1,1 with bits 1,x,x,0,x,0,1 → single word 4'b1001. No state change on idle cycles.
